// File: rtl/note_player_if.sv
// Note request handshake between a note sequencer (master) and note_player (slave).
interface note_player_if;
  logic       in_vld;
  logic       in_rdy;
  logic [3:0] in_note;
  logic [1:0] in_oct;
  logic [9:0] in_dur_ms;

  modport master (output in_vld, in_note, in_oct, in_dur_ms, input in_rdy);
  modport slave  (input in_vld, in_note, in_oct, in_dur_ms, output in_rdy);
endinterface

// File: rtl/note_player.sv
// Square-wave tone transmitter: plays a requested pitch for N ms, then a fixed silent gap.
// Define NOTE_PLAYER_ENVELOPE_EN to halve the amplitude every DECAY_MS ms while playing.
module note_player #(
  parameter int unsigned CLK_MHZ  = 50,
  parameter logic [15:0] AMP      = 16'h2000,
  parameter int unsigned GAP_MS   = 20,
  parameter int unsigned DECAY_MS = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  note_player_if.slave req,
  output logic [15:0]  sound_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [23:0]     MS_CYCLES = 24'(CLK_MHZ * 1000);
  localparam logic [23:0]     GAP_TICKS = 24'(GAP_MS);
  localparam longint unsigned HP_NUM    = 64'(CLK_MHZ) * 64'd50_000_000;

  if (DECAY_MS == 0) begin : gDecayCheck
    $error("note_player: DECAY_MS must be at least 1");
  end

  // Octave-4 half-periods in clock cycles; frequencies are in centi-Hz.
  function automatic logic [23:0] baseHalfPeriod(input logic [3:0] note);
    logic [23:0] hp;
    case (note)
      4'd0:    hp = 24'(HP_NUM / 64'd26163);
      4'd1:    hp = 24'(HP_NUM / 64'd27718);
      4'd2:    hp = 24'(HP_NUM / 64'd29366);
      4'd3:    hp = 24'(HP_NUM / 64'd31113);
      4'd4:    hp = 24'(HP_NUM / 64'd32963);
      4'd5:    hp = 24'(HP_NUM / 64'd34923);
      4'd6:    hp = 24'(HP_NUM / 64'd36999);
      4'd7:    hp = 24'(HP_NUM / 64'd39200);
      4'd8:    hp = 24'(HP_NUM / 64'd41530);
      4'd9:    hp = 24'(HP_NUM / 64'd44000);
      4'd10:   hp = 24'(HP_NUM / 64'd46616);
      4'd11:   hp = 24'(HP_NUM / 64'd49388);
      default: hp = 24'(HP_NUM / 64'd26163);
    endcase
    return hp;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  note_q, note_d;
  logic [23:0] hpReload_q, hpReload_d;
  logic [23:0] hpCnt_q, hpCnt_d;
  logic [23:0] msCnt_q, msCnt_d;
  logic [23:0] durCnt_q, durCnt_d;
  logic        pol_q, pol_d;
  logic        done_q, done_d;
  logic [15:0] sound_q, sound_d;
  logic [15:0] ampNow;
  logic        accept;
  logic        tick;
  logic [23:0] hpNew;

  assign req.in_rdy = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);
  assign sound_o    = sound_q;
  assign done_o     = done_q;
  assign accept     = req.in_vld && (state_q == IDLE);
  assign tick       = (msCnt_q == MS_CYCLES - 24'd1);
  assign hpNew      = baseHalfPeriod(req.in_note) >> req.in_oct;

`ifdef NOTE_PLAYER_ENVELOPE_EN
  localparam logic [23:0] DECAY_TICKS = 24'(DECAY_MS);

  logic [15:0] amp_q, amp_d;
  logic [23:0] decayCnt_q, decayCnt_d;

  always_comb begin
    amp_d      = amp_q;
    decayCnt_d = decayCnt_q;
    if (accept) begin
      amp_d      = AMP;
      decayCnt_d = '0;
    end else if (state_q == PLAY && tick) begin
      if (decayCnt_q + 24'd1 >= DECAY_TICKS) begin
        decayCnt_d = '0;
        amp_d      = amp_q >> 1;
      end else begin
        decayCnt_d = decayCnt_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      amp_q      <= AMP;
      decayCnt_q <= '0;
    end else begin
      amp_q      <= amp_d;
      decayCnt_q <= decayCnt_d;
    end
  end

  assign ampNow = amp_q;
`else
  assign ampNow = AMP;
`endif

  always_comb begin
    state_d    = state_q;
    note_d     = note_q;
    hpReload_d = hpReload_q;
    hpCnt_d    = hpCnt_q;
    pol_d      = pol_q;
    msCnt_d    = tick ? '0 : msCnt_q + 24'd1;
    durCnt_d   = durCnt_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        msCnt_d = '0;
        if (accept) begin
          note_d     = req.in_note;
          hpReload_d = hpNew;
          hpCnt_d    = hpNew - 24'd1;
          pol_d      = 1'b1;
          if (req.in_dur_ms != '0) begin
            state_d  = PLAY;
            durCnt_d = 24'(req.in_dur_ms);
          end else begin
            state_d  = GAP;
            durCnt_d = GAP_TICKS;
          end
        end
      end

      PLAY: begin
        if (hpCnt_q == '0) begin
          pol_d   = !pol_q;
          hpCnt_d = hpReload_q - 24'd1;
        end else begin
          hpCnt_d = hpCnt_q - 24'd1;
        end
        // The prescaler wraps to zero on this tick, so GAP entry starts a fresh ms.
        if (tick) begin
          if (durCnt_q == 24'd1) begin
            state_d  = GAP;
            durCnt_d = GAP_TICKS;
          end else begin
            durCnt_d = durCnt_q - 24'd1;
          end
        end
      end

      GAP: begin
        if (GAP_TICKS == '0 || (tick && durCnt_q == 24'd1)) begin
          state_d  = IDLE;
          durCnt_d = '0;
          msCnt_d  = '0;
          done_d   = 1'b1;
        end else if (tick) begin
          durCnt_d = durCnt_q - 24'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    sound_d = '0;
    if (state_q == PLAY && note_q < 4'd12) begin
      sound_d = pol_q ? ampNow : (~ampNow + 16'd1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      note_q     <= '0;
      hpReload_q <= '0;
      hpCnt_q    <= '0;
      msCnt_q    <= '0;
      durCnt_q   <= '0;
      pol_q      <= 1'b1;
      done_q     <= 1'b0;
      sound_q    <= '0;
    end else begin
      state_q    <= state_d;
      note_q     <= note_d;
      hpReload_q <= hpReload_d;
      hpCnt_q    <= hpCnt_d;
      msCnt_q    <= msCnt_d;
      durCnt_q   <= durCnt_d;
      pol_q      <= pol_d;
      done_q     <= done_d;
      sound_q    <= sound_d;
    end
  end

endmodule
